// File: rtl/stack_sequencer.sv
// Push/pop sequencer between the four-entry register file and data memory.
// Moves ACC/RA to or from the downward-growing stack and then writes back SP.
module stack_sequencer #(
    parameter logic [15:0] STACK_BASE  = 16'hFFFF,
    parameter logic [15:0] STACK_LIMIT = 16'hFF00
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] SP,
    input  logic [15:0] ACC,
    input  logic [15:0] RA,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        write,
    output logic [1:0]  Dest,
    output logic [15:0] wrData,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_MEM     = 3'd1;
    localparam logic [2:0] S_WB_DATA = 3'd2;
    localparam logic [2:0] S_WB_SP   = 3'd3;
    localparam logic [2:0] S_ERR     = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] sp_q, sp_d;
    // Holds the push source value, then reused for the popped data.
    logic [15:0] val_q, val_d;

    logic        start_pop;
    logic        start_fault;
    logic        pop_q;
    logic [15:0] sp_inc;
    logic [15:0] sp_dec;

    assign start_pop   = op[0];
    assign start_fault = start_pop ? (SP == STACK_BASE) : (SP == STACK_LIMIT);
    assign pop_q       = op_q[0];
    assign sp_inc      = sp_q + 16'd1;
    assign sp_dec      = sp_q - 16'd1;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sp_d    = sp_q;
        val_d   = val_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    sp_d    = SP;
                    val_d   = op[1] ? RA : ACC;
                    state_d = start_fault ? S_ERR : S_MEM;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (pop_q) begin
                        val_d   = mem_rdata;
                        state_d = S_WB_DATA;
                    end else begin
                        state_d = S_WB_SP;
                    end
                end
            end
            S_WB_DATA: state_d = S_WB_SP;
            S_WB_SP:   state_d = S_IDLE;
            S_ERR:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            sp_q    <= 16'h0000;
            val_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sp_q    <= sp_d;
            val_q   <= val_d;
        end
    end

    // Outputs decode from registered state only, so they are quiet in IDLE.
    always_comb begin
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        write     = 1'b0;
        Dest      = 2'b00;
        wrData    = 16'h0000;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            S_MEM: begin
                mem_addr  = pop_q ? sp_inc : sp_q;
                mem_wdata = pop_q ? 16'h0000 : val_q;
                mem_we    = ~pop_q;
                mem_re    = pop_q;
            end
            S_WB_DATA: begin
                write  = 1'b1;
                Dest   = {op_q[1], op_q[1]};
                wrData = val_q;
            end
            S_WB_SP: begin
                write  = 1'b1;
                Dest   = 2'b10;
                wrData = pop_q ? sp_inc : sp_dec;
                done   = 1'b1;
            end
            S_ERR: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: directed vector table, hand-written corner
// sequences, and a randomized run against a transaction-level stack model.
module tb_stack_sequencer;

    localparam logic [15:0] BASE  = 16'hFFFF;
    localparam logic [15:0] LIMIT = 16'hFF00;

    logic        CLK = 1'b0;
    logic        rst, start, mem_ready;
    logic [1:0]  op;
    logic [15:0] mem_rdata;
    logic [15:0] sp_r, acc_r, ra_r;
    logic [15:0] SP, ACC, RA;
    logic [15:0] mem_addr, mem_wdata, wrData;
    logic        mem_we, mem_re, write, busy, done, err;
    logic [1:0]  Dest;

    assign SP  = sp_r;
    assign ACC = acc_r;
    assign RA  = ra_r;

    always #5 CLK = ~CLK;

    stack_sequencer #(.STACK_BASE(BASE), .STACK_LIMIT(LIMIT)) dut (
        .CLK(CLK), .rst(rst), .start(start), .op(op),
        .SP(SP), .ACC(ACC), .RA(RA),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .write(write), .Dest(Dest), .wrData(wrData),
        .busy(busy), .done(done), .err(err)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic        rst, start;
        logic [1:0]  op;
        logic [15:0] sp, acc, ra, rdata;
        logic        ready;
        logic [15:0] e_addr, e_wdata;
        logic        e_we, e_re, e_write;
        logic [1:0]  e_dest;
        logic [15:0] e_wr;
        logic        e_busy, e_done, e_err;
    } vec_t;

    function automatic vec_t mk(
        input logic r, input logic s, input logic [1:0] o,
        input logic [15:0] sp, input logic [15:0] acc, input logic [15:0] ra,
        input logic [15:0] rd, input logic rdy,
        input logic [15:0] a, input logic [15:0] wd, input logic we, input logic re,
        input logic w, input logic [1:0] d, input logic [15:0] wr,
        input logic b, input logic dn, input logic e);
        vec_t v;
        v.rst = r; v.start = s; v.op = o; v.sp = sp; v.acc = acc; v.ra = ra;
        v.rdata = rd; v.ready = rdy; v.e_addr = a; v.e_wdata = wd; v.e_we = we;
        v.e_re = re; v.e_write = w; v.e_dest = d; v.e_wr = wr; v.e_busy = b;
        v.e_done = dn; v.e_err = e;
        return v;
    endfunction

    // Stack memory as seen by the bench, and the model's own copy.
    logic [15:0] bmem [logic [15:0]];
    logic [15:0] mmem [logic [15:0]];

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction
    function automatic logic [15:0] bm_rd(input logic [15:0] a);
        return bmem.exists(a) ? bmem[a] : init_val(a);
    endfunction
    function automatic logic [15:0] mm_rd(input logic [15:0] a);
        return mmem.exists(a) ? mmem[a] : init_val(a);
    endfunction

    vec_t vt[$];

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; mem_ready = 1'b0; mem_rdata = 16'h0;
        sp_r = BASE; acc_r = 16'h0; ra_r = 16'h0;
        repeat (2) tick();

        //         rst s op  SP       ACC      RA       rdata    rdy  addr     wdata    we re wr d  wrData   b  dn e
        vt.push_back(mk(1, 0, 0, 16'hFFFF, 16'h1234, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
        vt.push_back(mk(0, 1, 0, 16'hFFFF, 16'h1234, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 16'hFFFF, 16'h1234, 16'h0000, 16'h0000, 1, 16'hFFFF, 16'h1234, 1, 0, 0, 0, 16'h0000, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 16'hFFFF, 16'h1234, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 1, 2, 16'hFFFE, 1, 1, 0));
        vt.push_back(mk(0, 1, 1, 16'hFFFE, 16'h0000, 16'h0000, 16'h1234, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 16'hFFFE, 16'h0000, 16'h0000, 16'h1234, 1, 16'hFFFF, 16'h0000, 0, 1, 0, 0, 16'h0000, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 16'hFFFE, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h1234, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 16'hFFFE, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 1, 2, 16'hFFFF, 1, 1, 0));
        vt.push_back(mk(0, 1, 1, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 1, 1));
        vt.push_back(mk(0, 1, 2, 16'hFF00, 16'h0000, 16'h00AB, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 16'hFF00, 16'h0000, 16'h00AB, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 1, 1));
        vt.push_back(mk(0, 1, 2, 16'hFF01, 16'h0000, 16'h00AB, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 16'hFF01, 16'h0000, 16'h00AB, 16'h0000, 1, 16'hFF01, 16'h00AB, 1, 0, 0, 0, 16'h0000, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 16'hFF01, 16'h0000, 16'h00AB, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 1, 2, 16'hFF00, 1, 1, 0));
        vt.push_back(mk(0, 1, 3, 16'hFF80, 16'h0000, 16'h0000, 16'hBEEF, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 16'hFF80, 16'h0000, 16'h0000, 16'hBEEF, 1, 16'hFF81, 16'h0000, 0, 1, 0, 0, 16'h0000, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 16'hFF80, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 1, 3, 16'hBEEF, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 16'hFF80, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 1, 2, 16'hFF81, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 16'hFF80, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 16'hFF80, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));

        // Each row: outputs observed this cycle, inputs sampled at the coming edge.
        for (int i = 0; i < vt.size(); i++) begin
            vec_t v;
            v = vt[i];
            rst = v.rst; start = v.start; op = v.op; sp_r = v.sp; acc_r = v.acc;
            ra_r = v.ra; mem_rdata = v.rdata; mem_ready = v.ready;
            chk($sformatf("row%0d.we", i), mem_we, v.e_we);
            chk($sformatf("row%0d.re", i), mem_re, v.e_re);
            chk($sformatf("row%0d.write", i), write, v.e_write);
            chk($sformatf("row%0d.busy", i), busy, v.e_busy);
            chk($sformatf("row%0d.done", i), done, v.e_done);
            chk($sformatf("row%0d.err", i), err, v.e_err);
            if (v.e_we || v.e_re || v.rst) chk($sformatf("row%0d.addr", i), mem_addr, v.e_addr);
            if (v.e_we || v.rst) chk($sformatf("row%0d.wdata", i), mem_wdata, v.e_wdata);
            if (v.e_write || v.rst) begin
                chk($sformatf("row%0d.dest", i), Dest, v.e_dest);
                chk($sformatf("row%0d.wrData", i), wrData, v.e_wr);
            end
            tick();
        end

        // Stalled push: strobe and payload hold, stray starts ignored, one done.
        begin
            int dones;
            dones = 0;
            sp_r = 16'hFFF0; acc_r = 16'h5A5A; op = 2'b00; start = 1'b1; mem_ready = 1'b0;
            tick();
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("stall%0d.we", i), mem_we, 1'b1);
                chk($sformatf("stall%0d.addr", i), mem_addr, 16'hFFF0);
                chk($sformatf("stall%0d.wdata", i), mem_wdata, 16'h5A5A);
                if (done) dones++;
                start = 1'b1; op = 2'($urandom); acc_r = 16'($urandom); mem_ready = 1'b0;
                tick();
            end
            chk("stall.we_last", mem_we, 1'b1);
            start = 1'b0; mem_ready = 1'b1;
            tick();
            if (done) dones++;
            chk("stall.wb_sp", wrData, 16'hFFEF);
            mem_ready = 1'b0;
            tick();
            if (done) dones++;
            chk("stall.idle_busy", busy, 1'b0);
            tick();
            if (done) dones++;
            chk("stall.no_queue", busy, 1'b0);
            chk("stall.done_count", 16'(dones), 16'd1);
        end

        // Reset during the memory phase of a pop.
        begin
            int writes;
            writes = 0;
            sp_r = 16'hFFF0; op = 2'b01; start = 1'b1; mem_ready = 1'b0;
            tick();
            start = 1'b0;
            chk("rstmem.re", mem_re, 1'b1);
            rst = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h1111;
            tick();
            rst = 1'b0; mem_ready = 1'b0;
            chk("rstmem.busy", busy, 1'b0);
            chk("rstmem.re_drop", mem_re, 1'b0);
            chk("rstmem.addr", mem_addr, 16'h0000);
            chk("rstmem.wrData", wrData, 16'h0000);
            chk("rstmem.done", done, 1'b0);
            for (int i = 0; i < 3; i++) begin
                if (write) writes++;
                tick();
            end
            if (write) writes++;
            chk("rstmem.write_count", 16'(writes), 16'd0);
        end

        // Randomized run: bench plays register file and memory, model tracks the stack.
        begin
            logic [15:0] m_sp, m_acc, m_ra, v;
            logic        exp_err, got_done;
            sp_r = BASE; acc_r = 16'h0; ra_r = 16'h0;
            m_sp = BASE; m_acc = 16'h0; m_ra = 16'h0;
            for (int t = 0; t < 150; t++) begin
                int pick;
                int cyc;
                logic [1:0] top;
                pick = $urandom_range(0, 9);
                case (pick)
                    0: begin sp_r = LIMIT;         m_sp = LIMIT;         end
                    1: begin sp_r = LIMIT + 16'd1; m_sp = LIMIT + 16'd1; end
                    2: begin sp_r = BASE;          m_sp = BASE;          end
                    3: begin sp_r = BASE - 16'd1;  m_sp = BASE - 16'd1;  end
                    default: ;
                endcase
                if ($urandom_range(0, 1) == 1) begin acc_r = 16'($urandom); m_acc = acc_r; end
                if ($urandom_range(0, 1) == 1) begin ra_r = 16'($urandom); m_ra = ra_r; end
                repeat ($urandom_range(0, 2)) begin
                    start = 1'b0; mem_ready = 1'($urandom);
                    chk("rnd.idle_busy", busy, 1'b0);
                    tick();
                end
                top = 2'($urandom);
                op = top; start = 1'b1; mem_ready = 1'($urandom);
                exp_err = 1'b0;
                if (!top[0]) begin
                    if (m_sp == LIMIT) exp_err = 1'b1;
                    else begin
                        mmem[m_sp] = top[1] ? m_ra : m_acc;
                        m_sp = m_sp - 16'd1;
                    end
                end else begin
                    if (m_sp == BASE) exp_err = 1'b1;
                    else begin
                        v = mm_rd(m_sp + 16'd1);
                        if (top[1]) m_ra = v; else m_acc = v;
                        m_sp = m_sp + 16'd1;
                    end
                end
                tick();
                got_done = 1'b0;
                cyc = 0;
                while (!got_done && cyc < 40) begin
                    logic        w, we, rdy;
                    logic [1:0]  d;
                    logic [15:0] wd, a, dat;
                    w = write; d = Dest; wd = wrData; we = mem_we; a = mem_addr; dat = mem_wdata;
                    if (done) begin
                        got_done = 1'b1;
                        chk($sformatf("rnd%0d.err", t), err, exp_err);
                    end
                    if (err) chk($sformatf("rnd%0d.err_with_done", t), done, 1'b1);
                    if (w && d == 2'b01) chk($sformatf("rnd%0d.dest_acco", t), d, 2'b00);
                    rdy = ($urandom_range(0, 2) == 0);
                    mem_ready = rdy;
                    mem_rdata = mem_re ? bm_rd(a) : 16'($urandom);
                    start = ($urandom_range(0, 3) == 0);
                    op = 2'($urandom);
                    tick();
                    cyc++;
                    if (w) begin
                        case (d)
                            2'b00: acc_r = wd;
                            2'b10: sp_r = wd;
                            2'b11: ra_r = wd;
                            default: ;
                        endcase
                    end
                    if (we && rdy) bmem[a] = dat;
                end
                start = 1'b0;
                if (!got_done) begin
                    n_chk++; n_fail++;
                    $display("FAIL rnd%0d.timeout: no done within 40 cycles", t);
                    t = 150;
                end else begin
                    chk($sformatf("rnd%0d.sp", t), sp_r, m_sp);
                    chk($sformatf("rnd%0d.acc", t), acc_r, m_acc);
                    chk($sformatf("rnd%0d.ra", t), ra_r, m_ra);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
